// File: rtl/dnn_result_reader.sv
// dnn_result_reader: sequences one inference run, sweeps class scores and returns the signed argmax
// Ports:
//   clk, rst (async, active low)
//   req / busy                   : host request, busy outside IDLE
//   dnn_reset, dnn_start         : one-cycle pulses to the inference top
//   dnn_done                     : level completion flag from the inference top
//   out_idx / out_val            : registered class select and its combinational score
//   result_valid / result_ack    : result handshake, held until acked
//   result_class, result_score   : argmax index and maximum score
//   result_err                   : run timed out; class and score are zero
module dnn_result_reader #(
  parameter int DATA_WIDTH     = 16,
  parameter int NUM_CLASSES    = 10,
  parameter int IDX_WIDTH      = 4,
  parameter int TIMEOUT_CYCLES = 1048576
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         req,
  output logic                         busy,
  output logic                         dnn_reset,
  output logic                         dnn_start,
  input  logic                         dnn_done,
  output logic [IDX_WIDTH-1:0]         out_idx,
  input  logic signed [DATA_WIDTH-1:0] out_val,
  output logic                         result_valid,
  input  logic                         result_ack,
  output logic [IDX_WIDTH-1:0]         result_class,
  output logic signed [DATA_WIDTH-1:0] result_score,
  output logic                         result_err
);
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [IDX_WIDTH-1:0] LAST = IDX_WIDTH'(NUM_CLASSES - 1);
  typedef enum logic [2:0] {IDLE, CLR, START, WAIT, SCAN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] cnt;
  logic timeout;
  // dnn_done wins over an expiring counter in the same cycle
  assign timeout = !dnn_done && cnt == TMAX;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else state <= nxt;
  end
  always_comb begin
    nxt          = state;
    busy         = state != IDLE;
    dnn_reset    = state == CLR;
    dnn_start    = state == START;
    result_valid = state == DONE;
    case (state)
      IDLE:    nxt = req ? CLR : IDLE;
      CLR:     nxt = START;
      START:   nxt = WAIT;
      WAIT:    nxt = dnn_done ? SCAN : timeout ? DONE : WAIT;
      SCAN:    nxt = out_idx == LAST ? DONE : SCAN;
      DONE:    nxt = result_ack ? IDLE : DONE;
      default: nxt = IDLE;
    endcase
  end
  // result_class/result_score double as the running best so a finished result
  // persists after ack until the next SCAN or timeout replaces it
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt          <= '0;
      out_idx      <= '0;
      result_class <= '0;
      result_score <= '0;
      result_err   <= 1'b0;
    end else begin
      cnt <= state == CLR ? '0 : state == WAIT ? cnt + 1'b1 : cnt;
      if (state == WAIT && timeout) begin
        result_err   <= 1'b1;
        result_class <= '0;
        result_score <= '0;
      end
      if (state == SCAN) begin
        out_idx <= out_idx == LAST ? '0 : out_idx + 1'b1;
        if (out_idx == '0 || out_val > result_score) begin
          result_class <= out_idx;
          result_score <= out_val;
        end
        if (out_idx == LAST) result_err <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dnn_result_reader.sv
// tb_dnn_result_reader: randomized self-checking bench with an argmax reference model
module tb_dnn_result_reader;
  localparam int DW = 16, N = 10, IW = 4, TO = 64;
  logic clk = 0, rst = 0, req = 0, result_ack = 0;
  logic busy, dnn_reset, dnn_start, dnn_done, result_valid, result_err;
  logic [IW-1:0] out_idx, result_class;
  logic signed [DW-1:0] out_val, result_score;
  logic signed [DW-1:0] scores [N];
  int dly = -1, since = -1;
  int total = 0, bad = 0;
  int exp_cls = 0, exp_err = 0;
  longint exp_score = 0;
  dnn_result_reader #(.DATA_WIDTH(DW), .NUM_CLASSES(N), .IDX_WIDTH(IW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst), .req(req), .busy(busy), .dnn_reset(dnn_reset), .dnn_start(dnn_start),
    .dnn_done(dnn_done), .out_idx(out_idx), .out_val(out_val), .result_valid(result_valid),
    .result_ack(result_ack), .result_class(result_class), .result_score(result_score),
    .result_err(result_err)
  );
  always #5 clk = ~clk;
  // inference top model: done rises dly cycles into WAIT and stays high until the next clear
  always @(posedge clk) begin
    if (dnn_reset) since <= -1;
    else if (dnn_start) since <= 0;
    else if (since >= 0) since <= since + 1;
  end
  assign dnn_done = dly >= 0 && since >= dly;
  assign out_val = out_idx < N ? scores[out_idx] : 16'sh5555;
  task automatic chk(input string tag, input longint got, input longint exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask
  task automatic run(input int d, input int hold, input bit ackreq);
    int n, nres, nst, nz, mx, c;
    longint s;
    dly = d;
    req = 1;
    @(negedge clk);
    req = 0;
    chk("reset_pulse", dnn_reset, 1);
    chk("start_early", dnn_start, 0);
    chk("busy_run", busy, 1);
    @(negedge clk);
    chk("start_pulse", dnn_start, 1);
    chk("reset_once", dnn_reset, 0);
    chk("retain_class", result_class, exp_cls);
    chk("retain_score", result_score, exp_score);
    n = 2; nres = 1; nst = 1; nz = 0; mx = 0;
    while (!result_valid && n < 300) begin
      @(negedge clk);
      n++;
      req = 1'($urandom % 2);
      nres += int'(dnn_reset);
      nst += int'(dnn_start);
      if (out_idx != 0) nz++;
      if (int'(out_idx) > mx) mx = int'(out_idx);
    end
    c = 0; s = 0;
    if (d < 0) begin
      exp_err = 1;
    end else begin
      exp_err = 0;
      s = scores[0];
      for (int i = 1; i < N; i++) if (scores[i] > s) begin s = scores[i]; c = i; end
    end
    exp_cls = c;
    exp_score = s;
    chk("latency", n, d < 0 ? TO + 3 : d + N + 4);
    chk("reset_count", nres, 1);
    chk("start_count", nst, 1);
    chk("idx_nonzero", nz, d < 0 ? 0 : N - 1);
    chk("idx_max", mx, d < 0 ? 0 : N - 1);
    chk("class", result_class, exp_cls);
    chk("score", result_score, exp_score);
    chk("err", result_err, exp_err);
    repeat (hold) begin
      @(negedge clk);
      req = 1'($urandom % 2);
    end
    chk("hold_valid", result_valid, 1);
    chk("hold_busy", busy, 1);
    chk("hold_class", result_class, exp_cls);
    chk("hold_score", result_score, exp_score);
    result_ack = 1;
    req = ackreq;
    @(negedge clk);
    result_ack = 0;
    req = 0;
    chk("ack_idle", busy, 0);
    chk("ack_valid", result_valid, 0);
    if (ackreq) begin
      @(negedge clk);
      chk("ack_req_ignored", dnn_reset, 0);
      chk("after_ack_class", result_class, exp_cls);
    end
  endtask
  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int np;
    for (int i = 0; i < N; i++) scores[i] = 0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", result_valid, 0);
    rst = 1;
    @(negedge clk);
    chk("idle_busy", busy, 0);
    dly = -1;
    req = 1;
    @(negedge clk);
    req = 0;
    repeat (8) @(negedge clk);
    chk("midwait_busy", busy, 1);
    #2 rst = 0;
    #1;
    chk("async_busy", busy, 0);
    chk("async_start", dnn_start, 0);
    chk("async_reset", dnn_reset, 0);
    chk("async_idx", out_idx, 0);
    chk("async_valid", result_valid, 0);
    chk("async_class", result_class, 0);
    chk("async_score", result_score, 0);
    chk("async_err", result_err, 0);
    @(negedge clk);
    rst = 1;
    np = 0;
    repeat (6) begin
      @(negedge clk);
      np += int'(dnn_reset) + int'(dnn_start) + int'(busy);
    end
    chk("idle_no_pulses", np, 0);
    scores = '{-16'sd5, 16'sd3, 16'sd12, 16'sd7, -16'sd100, 16'sd0, 16'sd11, 16'sd2, 16'sd1, -16'sd1};
    run(49, 20, 1);
    for (int i = 0; i < N; i++) scores[i] = -16'sd32768;
    scores[4] = -16'sd3;
    scores[7] = -16'sd3;
    run(30, 3, 1);
    run(-1, 5, 1);
    scores[9] = 16'sd100;
    run(63, 0, 0);
    for (int i = 0; i < N; i++) scores[i] = DW'($urandom_range(0, 30000));
    scores[9] = 16'sd32767;
    run(10, 2, 1);
    for (int r = 0; r < 20; r++) begin
      for (int i = 0; i < N; i++)
        scores[i] = ($urandom % 2) ? DW'($urandom_range(0, 3)) - 16'sd2 : DW'($urandom);
      run(($urandom % 5 == 0) ? -1 : int'($urandom_range(0, 63)), int'($urandom_range(0, 25)), 1'($urandom % 2));
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/dnn_result_reader.md
Name: dnn_result_reader

Overview:
- Initiator-side controller for the inference top.
- Kicks off one classification by sequencing dnn_reset then dnn_start, and waits for dnn_done.
- Sweeps out_idx over all class outputs, computes the signed argmax, and presents class and score through a valid/ack handshake to the host/testbench sequencer.
- Sits between the host control logic and the inference top's start/reset/done/out_idx/out interface.

Parameters:
- DATA_WIDTH, 16: width of the signed two's-complement class score.
- NUM_CLASSES, 10: number of class outputs swept (1..16).
- IDX_WIDTH, 4: out_idx/result_class width.
- TIMEOUT_CYCLES, 1048576: maximum WAIT cycles before the error abort.

Ports:
- clk, input, 1: clock, rising edge.
- rst, input, 1: asynchronous, active-low reset.
- req, input, 1: request one classification; sampled only in IDLE.
- busy, output, 1: high in every state except IDLE.
- dnn_reset, output, 1: one-cycle clear pulse to the inference top.
- dnn_start, output, 1: one-cycle start pulse to the inference top.
- dnn_done, input, 1: level completion flag from the inference top.
- out_idx, output, IDX_WIDTH: class select; registered.
- out_val, input, DATA_WIDTH signed: selected class score; combinational function of out_idx.
- result_valid, output, 1: result available; held until acked.
- result_ack, input, 1: consumer accepts the result.
- result_class, output, IDX_WIDTH: argmax index.
- result_score, output, DATA_WIDTH signed: maximum score.
- result_err, output, 1: timeout occurred; class and score are invalid.

Behaviour:
- Reset (rst low, asynchronous): state IDLE, all outputs 0, best/count registers 0. Reset mid-operation aborts immediately; no pulse is completed.
- All control outputs are Moore outputs decoded from the registered state.

State machine:
- IDLE: if req, go to CLR. result_valid=0.
- CLR (1 cycle): dnn_reset=1, timeout counter cleared. Always go to START.
- START (1 cycle): dnn_start=1. Always go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - If dnn_done is high: go to SCAN with out_idx=0.
  - Else if counter reaches TIMEOUT_CYCLES-1: go to DONE with result_err=1, result_class=0, result_score=0.
  - dnn_done has priority over timeout in the same cycle.
- SCAN (exactly NUM_CLASSES cycles):
  - Each cycle samples out_val for the current registered out_idx.
  - idx 0 loads best unconditionally.
  - Later idx updates best only if out_val > best (signed, strict). Ties keep the lowest index.
  - out_idx increments each cycle.
  - After idx NUM_CLASSES-1 is sampled: go to DONE, out_idx returns to 0, result_err=0.
- DONE: result_valid=1; result_class/score/err stable. On result_ack go to IDLE.

Handshake and timing:
- req while busy is ignored; no queueing.
- req asserted in the same cycle as the ack'ing DONE cycle is ignored; the next req is accepted in IDLE.
- result_class/score/err retain their values after ack until the next SCAN or timeout overwrites them.
- Latency: req seen at edge T gives dnn_reset high in cycle T+1 and dnn_start high in T+2. WAIT starts at T+3. First dnn_done seen at edge D gives result_valid high in cycle D+NUM_CLASSES+1.
- Arithmetic: comparison is full-width signed; no saturation or rounding. out_idx never exceeds NUM_CLASSES-1.

Test Plan:
1. Reset then idle: hold rst low mid-WAIT, release -> busy=0, dnn_start=0, dnn_reset=0, out_idx=0, result_valid=0; no pulses until req.
2. Nominal: req=1 one cycle; dnn model asserts done 50 cycles after dnn_start; scores {-5,3,12,7,-100,0,11,2,1,-1} -> exactly one dnn_reset pulse then one dnn_start pulse; out_idx sweeps 0..9; result_valid=1 with class=2, score=12, err=0, held until ack.
3. Tie and negative: scores all -32768 except idx 4 and 7 = -3 -> class=4, score=-3 (lowest index on tie, signed compare).
4. Timeout: TIMEOUT_CYCLES=64, dnn_done never asserted -> result_valid after 64 WAIT cycles with err=1, class=0, score=0; out_idx stays 0.
5. Handshake: hold ack low 20 cycles, pulse req during SCAN and DONE -> result stable, req ignored, busy=1; ack -> IDLE next cycle, exactly one run performed.
6. Back-to-back: second req in the cycle after ack with new scores (max at idx 9 = 32767) -> second result class=9, score=32767; the first run's result is unaffected until the new SCAN starts.
